// File: rtl/coin_pkg.sv
// Coin values, state encoding and coin-choice payload shared by the change dispenser.
package coin_pkg;

    localparam int unsigned AMT_W = 8;

    localparam logic [AMT_W-1:0] NICKEL  = 8'd5;
    localparam logic [AMT_W-1:0] DIME    = 8'd10;
    localparam logic [AMT_W-1:0] QUARTER = 8'd25;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        REQ    = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4,
        FAULT  = 3'd5
    } state_t;

    // One-hot coin choice, MSB first: quarter, dime, nickel.
    typedef struct packed {
        logic quarter;
        logic dime;
        logic nickel;
    } coin_t;

    typedef struct packed {
        coin_t             coin;
        logic [AMT_W-1:0]  value;
    } coin_sel_t;

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin not exceeding the amount still owed.
module coin_select
    import coin_pkg::*;
(
    input  logic [AMT_W-1:0] remaining,
    output coin_sel_t        choice
);

    // Priority compare from the largest coin down; nothing chosen below a nickel.
    always_comb begin
        choice = '0;
        if (remaining >= QUARTER) begin
            choice.coin.quarter = 1'b1;
            choice.value        = QUARTER;
        end else if (remaining >= DIME) begin
            choice.coin.dime = 1'b1;
            choice.value     = DIME;
        end else if (remaining >= NICKEL) begin
            choice.coin.nickel = 1'b1;
            choice.value       = NICKEL;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: pays out an amount as quarters, dimes and nickels with a
// request/acknowledge handshake, a fixed inter-coin gap and an ack timeout.
module change_dispenser
    import coin_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    input  logic             coinAck,
    output logic             quarterOut,
    output logic             dimeOut,
    output logic             nickelOut,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [AMT_W-1:0] coinCount
);

    localparam int unsigned GAP_W = 4;
    localparam int unsigned ACK_W = 8;

    // Last count value of each dwell; GAP_LAST is unused when GAP_CYCLES is 0.
    localparam logic [GAP_W-1:0] GAP_LAST =
        (GAP_CYCLES == 0) ? GAP_W'(0) : GAP_W'(GAP_CYCLES - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    coin_sel_t        choice;
    coin_t            coin_q;
    coin_t            coin_d;
    logic [AMT_W-1:0] value_q;
    logic [AMT_W-1:0] value_d;
    logic [ACK_W-1:0] ack_cnt;
    logic [ACK_W-1:0] ack_cnt_d;
    logic [GAP_W-1:0] gap_cnt;
    logic [GAP_W-1:0] gap_cnt_d;
    logic [AMT_W-1:0] remaining_d;
    logic [AMT_W-1:0] coin_count_d;
    logic             busy_d;
    logic             done_d;
    logic             error_d;
    logic             fault_d;
    logic             amount_ok;
    logic             ack_in_req;

    coin_select u_coin_select (
        .remaining (remaining),
        .choice    (choice)
    );

    assign amount_ok  = ((amount % AMT_W'(5)) == AMT_W'(0));
    assign ack_in_req = (state == REQ) && coinAck;

    assign quarterOut = coin_q.quarter;
    assign dimeOut    = coin_q.dime;
    assign nickelOut  = coin_q.nickel;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && amount_ok) state_nxt = SELECT;
            end
            SELECT: begin
                if (remaining == AMT_W'(0)) state_nxt = DONE;
                else                        state_nxt = REQ;
            end
            REQ: begin
                if (coinAck)                  state_nxt = (GAP_CYCLES == 0) ? SELECT : GAP;
                else if (ack_cnt == ACK_LAST) state_nxt = FAULT;
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_nxt = SELECT;
            end
            DONE:    state_nxt = IDLE;
            FAULT:   state_nxt = FAULT;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath, decoded from the transition.
    always_comb begin
        busy_d       = (state_nxt != IDLE) && (state_nxt != FAULT);
        done_d       = (state_nxt == DONE);
        fault_d      = (state_nxt == FAULT);
        error_d      = (state == IDLE) && start && !amount_ok;
        coin_d       = '0;
        value_d      = value_q;
        remaining_d  = remaining;
        coin_count_d = coinCount;
        ack_cnt_d    = '0;
        gap_cnt_d    = '0;

        if (state == SELECT) value_d = choice.value;

        if (state_nxt == REQ) coin_d = (state == SELECT) ? choice.coin : coin_q;

        if ((state == IDLE) && start && amount_ok) begin
            remaining_d  = amount;
            coin_count_d = '0;
        end

        if (ack_in_req) begin
            remaining_d  = remaining - value_q;
            coin_count_d = (coinCount == AMT_W'(255)) ? coinCount : coinCount + AMT_W'(1);
        end

        if ((state == REQ) && (state_nxt == REQ)) ack_cnt_d = ack_cnt + ACK_W'(1);
        if ((state == GAP) && (state_nxt == GAP)) gap_cnt_d = gap_cnt + GAP_W'(1);
    end

    // Output and datapath registers; reset clears every output.
    always_ff @(posedge clk) begin
        if (reset) begin
            coin_q    <= '0;
            value_q   <= '0;
            ack_cnt   <= '0;
            gap_cnt   <= '0;
            remaining <= '0;
            coinCount <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            coin_q    <= coin_d;
            value_q   <= value_d;
            ack_cnt   <= ack_cnt_d;
            gap_cnt   <= gap_cnt_d;
            remaining <= remaining_d;
            coinCount <= coin_count_d;
            busy      <= busy_d;
            done      <= done_d;
            error     <= error_d;
            fault     <= fault_d;
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with default parameters.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] amount;
    logic       coinAck;
    logic       quarterOut;
    logic       dimeOut;
    logic       nickelOut;
    logic       busy;
    logic       done;
    logic       error;
    logic       fault;
    logic [7:0] remaining;
    logic [7:0] coinCount;

    int checks = 0;
    int errors = 0;

    change_dispenser #(.GAP_CYCLES(2), .ACK_TIMEOUT(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .amount     (amount),
        .coinAck    (coinAck),
        .quarterOut (quarterOut),
        .dimeOut    (dimeOut),
        .nickelOut  (nickelOut),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fault      (fault),
        .remaining  (remaining),
        .coinCount  (coinCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({quarterOut, dimeOut, nickelOut, busy, done, error, fault, remaining, coinCount});
    endfunction

    function automatic logic [31:0] coins();
        return 32'({quarterOut, dimeOut, nickelOut});
    endfunction

    // Wait (bounded) at falling edges until some coin line is high.
    task automatic wait_coin();
        int n = 0;
        while (coins() == 32'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Acknowledge the pending coin one cycle after it is seen.
    task automatic ack_coin(input string tag, input logic [31:0] exp_coin,
                            input logic [31:0] exp_rem, input logic [31:0] exp_cnt);
        wait_coin();
        chk({tag, "_coin"}, coins(), exp_coin);
        @(negedge clk);
        chk({tag, "_hold"}, coins(), exp_coin);
        coinAck = 1'b1;
        @(negedge clk);
        coinAck = 1'b0;
        chk({tag, "_low"},  coins(), 32'd0);
        chk({tag, "_rem"},  32'(remaining), exp_rem);
        chk({tag, "_cnt"},  32'(coinCount), exp_cnt);
    endtask

    initial begin
        int n;
        int pulses;

        reset   = 1'b1;
        start   = 1'b0;
        amount  = 8'd0;
        coinAck = 1'b0;

        // Reset held for two cycles.
        repeat (2) @(negedge clk);
        chk("reset_outs", all_outs(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_outs", all_outs(), 32'd0);

        // amount = 0: busy from N+1, done at N+2, idle at N+3.
        start  = 1'b1;
        amount = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("z_busy1", 32'(busy), 32'd1);
        chk("z_done1", 32'(done), 32'd0);
        @(negedge clk);
        chk("z_done2", 32'(done), 32'd1);
        chk("z_busy2", 32'(busy), 32'd1);
        chk("z_coins", coins(), 32'd0);
        @(negedge clk);
        chk("z_done3", 32'(done), 32'd0);
        chk("z_busy3", 32'(busy), 32'd0);

        // amount = 40: quarter, dime, nickel.
        start  = 1'b1;
        amount = 8'd40;
        @(negedge clk);
        start = 1'b0;
        chk("f_busy", 32'(busy), 32'd1);
        chk("f_rem0", 32'(remaining), 32'd40);
        ack_coin("f_q", 32'b100, 32'd15, 32'd1);
        ack_coin("f_d", 32'b010, 32'd5,  32'd2);
        ack_coin("f_n", 32'b001, 32'd0,  32'd3);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("f_pulses", 32'(pulses), 32'd1);
        chk("f_idle",   32'(busy), 32'd0);
        chk("f_rem",    32'(remaining), 32'd0);
        chk("f_cnt",    32'(coinCount), 32'd3);

        // amount = 17: rejected, prior results unchanged.
        start  = 1'b1;
        amount = 8'd17;
        @(negedge clk);
        start = 1'b0;
        chk("e_err",   32'(error), 32'd1);
        chk("e_busy",  32'(busy), 32'd0);
        chk("e_coins", coins(), 32'd0);
        @(negedge clk);
        chk("e_err2",  32'(error), 32'd0);
        chk("e_busy2", 32'(busy), 32'd0);
        chk("e_rem",   32'(remaining), 32'd0);
        chk("e_cnt",   32'(coinCount), 32'd3);
        chk("e_coin2", coins(), 32'd0);

        // amount = 25 with ack withheld: 64 cycles of quarterOut, then fault.
        start  = 1'b1;
        amount = 8'd25;
        @(negedge clk);
        start = 1'b0;
        wait_coin();
        n = 0;
        while (quarterOut && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("t_dwell", 32'(n), 32'd64);
        chk("t_fault", 32'(fault), 32'd1);
        chk("t_busy",  32'(busy), 32'd0);
        chk("t_coins", coins(), 32'd0);
        chk("t_rem",   32'(remaining), 32'd25);
        start   = 1'b1;
        amount  = 8'd10;
        coinAck = 1'b1;
        repeat (3) @(negedge clk);
        start   = 1'b0;
        coinAck = 1'b0;
        chk("t_stuck", 32'(fault), 32'd1);
        chk("t_rem2",  32'(remaining), 32'd25);
        chk("t_busy2", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("t_reset", all_outs(), 32'd0);
        @(negedge clk);

        // amount = 90: start during REQ ignored; reset mid-REQ clears everything.
        start  = 1'b1;
        amount = 8'd90;
        @(negedge clk);
        start = 1'b0;
        wait_coin();
        chk("s_coin", coins(), 32'b100);
        start  = 1'b1;
        amount = 8'd5;
        @(negedge clk);
        start = 1'b0;
        chk("s_hold", coins(), 32'b100);
        chk("s_rem",  32'(remaining), 32'd90);
        chk("s_busy", 32'(busy), 32'd1);
        coinAck = 1'b1;
        @(negedge clk);
        coinAck = 1'b0;
        chk("s_rem1", 32'(remaining), 32'd65);
        chk("s_cnt1", 32'(coinCount), 32'd1);
        wait_coin();
        chk("s_coin2", coins(), 32'b100);
        reset = 1'b1;
        @(negedge clk);
        chk("s_reset", all_outs(), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("s_after", all_outs(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/change_dispenser.md
CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have parameter GAP_CYCLES, default 2, setting the idle cycles between successive coin requests (range 0..15).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 64, setting the maximum cycles a coin request waits for coinAck before fault (range 1..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to dispense amount; sampled only in IDLE.
REQ-006 The block SHALL have port amount, input, 8 bits: change to dispense in cents, unsigned.
REQ-007 The block SHALL have port coinAck, input, 1 bit: the coin mechanism has ejected the requested coin.
REQ-008 The block SHALL have ports quarterOut, dimeOut and nickelOut, each output, 1 bit: requests to eject one coin, at most one high at a time.
REQ-009 The block SHALL have port busy, output, 1 bit: high in every state except IDLE and FAULT.
REQ-010 The block SHALL have port done, output, 1 bit: a 1-cycle pulse on completion.
REQ-011 The block SHALL have port error, output, 1 bit: a 1-cycle pulse when an amount is rejected.
REQ-012 The block SHALL have port fault, output, 1 bit: high and held when a coin acknowledge times out.
REQ-013 The block SHALL have port remaining, output, 8 bits: cents still owed.
REQ-014 The block SHALL have port coinCount, output, 8 bits: coins dispensed for the current request.

Function
REQ-015 The block SHALL implement states IDLE, SELECT, REQ, GAP, DONE and FAULT, with every output registered.
REQ-016 In IDLE, start=1 with amount mod 5 = 0 SHALL load remaining=amount, clear coinCount and enter SELECT on the next edge.
REQ-017 In IDLE, start=1 with amount mod 5 != 0 SHALL pulse error the next cycle, leave remaining and coinCount unchanged, dispense nothing and stay in IDLE.
REQ-018 In SELECT with remaining=0, the block SHALL enter DONE.
REQ-019 In SELECT with remaining>0, the block SHALL pick the largest coin not exceeding remaining (25, then 10, then 5) and enter REQ.
REQ-020 In REQ, the chosen coin line SHALL be high for every cycle spent in REQ and low in all other states.
REQ-021 In REQ, coinAck=1 SHALL subtract the coin value from remaining, increment coinCount, and enter GAP, or enter SELECT directly if GAP_CYCLES=0.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles, then enter SELECT.
REQ-023 A REQ dwell reaching ACK_TIMEOUT cycles without coinAck SHALL enter FAULT: coin lines low, fault=1, busy=0, remaining holds its value.
REQ-024 FAULT SHALL be left only by reset; start is ignored in FAULT.
REQ-025 DONE SHALL assert done for exactly one cycle and then return to IDLE; remaining and coinCount hold until the next accepted start.
REQ-026 Latency for amount=0 SHALL be: start at cycle N, busy=1 from N+1, done=1 at N+2, IDLE at N+3.
REQ-027 The block SHALL ignore start outside IDLE, and SHALL ignore coinAck outside REQ.
REQ-028 Arithmetic SHALL be unsigned 8-bit; remaining never underflows by construction, and coinCount saturates at 255.

Reset
REQ-029 Reset SHALL take priority over all inputs.
REQ-030 On any edge with reset=1, including mid-REQ or in FAULT, the block SHALL enter IDLE with all outputs 0.

Structure
REQ-031 Shared package coin_pkg SHALL hold the coin value constants (NICKEL=5, DIME=10, QUARTER=25) and the state encoding.
REQ-032 The block SHALL use one combinational sub-module, coin_select, which maps remaining to a one-hot coin choice and its value.

Verification
REQ-033 Reset asserted for 2 cycles -> all outputs 0, state IDLE.
REQ-034 amount=40, coinAck 1 cycle after each request -> quarter, dime, nickel in that order; coinCount=3; remaining=0; one done pulse.
REQ-035 amount=0 -> no coin line asserted, done exactly 2 cycles after start.
REQ-036 amount=17 -> error pulse 1 cycle after start, no coin lines, busy stays 0.
REQ-037 amount=25 with coinAck withheld -> quarterOut high for 64 cycles, then fault=1 and remaining=25 until reset.
REQ-038 start pulsed during REQ with amount=90 -> ignored and the first request completes; reset during REQ -> all outputs 0 on the next cycle.
